// File: rtl/sid_regbank.sv
// rtl/sid_regbank.sv - parametrised SID register bank with read-back and decaying bus latch
// Purpose: host-bus register file feeding NUM_VOICES voices plus the filter, with
//   edge-qualified single-shot accesses and a bus latch that fades to 0x00.
// Ports:
//   clk, n_reset          clock, asynchronous active-low reset
//   clk_en                chip-rate tick, only advances the latch decay counter
//   addr, data_in, n_cs, rw   host bus (n_cs active-low, rw=1 read)
//   data_out, data_oe     registered read data and read-in-progress flag
//   freq, pw, ctrl, ad, sr, ctrl_wr   flat per-voice fields (voice i in slice i)
//   fc, res_filt, mode_vol            filter fields
//   pot_x, pot_y, osc_in, env_in      read-only sources
module sid_regbank #(
  parameter int NUM_VOICES  = 3,
  parameter int ADDR_W      = 5,
  parameter int DECAY_TICKS = 2000
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     clk_en,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [7:0]               data_in,
  output logic [7:0]               data_out,
  output logic                     data_oe,
  input  logic                     n_cs,
  input  logic                     rw,
  output logic [16*NUM_VOICES-1:0] freq,
  output logic [12*NUM_VOICES-1:0] pw,
  output logic [8*NUM_VOICES-1:0]  ctrl,
  output logic [8*NUM_VOICES-1:0]  ad,
  output logic [8*NUM_VOICES-1:0]  sr,
  output logic [NUM_VOICES-1:0]    ctrl_wr,
  output logic [10:0]              fc,
  output logic [7:0]               res_filt,
  output logic [7:0]               mode_vol,
  input  logic [7:0]               pot_x,
  input  logic [7:0]               pot_y,
  input  logic [7:0]               osc_in,
  input  logic [7:0]               env_in
);

  localparam int B  = 7 * NUM_VOICES;
  localparam int CW = $clog2(DECAY_TICKS + 1);
  localparam logic [CW-1:0] DECAY_LAST = CW'(DECAY_TICKS - 1);

  if (7 * NUM_VOICES + 8 > 2 ** ADDR_W) begin : g_bad_addr_w
    $error("sid_regbank: ADDR_W too small for NUM_VOICES");
  end
  if (DECAY_TICKS < 1) begin : g_bad_decay
    $error("sid_regbank: DECAY_TICKS must be >= 1");
  end

  logic [16*NUM_VOICES-1:0] freq_q, freq_d;
  logic [12*NUM_VOICES-1:0] pw_q, pw_d;
  logic [8*NUM_VOICES-1:0]  ctrl_q, ctrl_d;
  logic [8*NUM_VOICES-1:0]  ad_q, ad_d;
  logic [8*NUM_VOICES-1:0]  sr_q, sr_d;
  logic [NUM_VOICES-1:0]    ctrl_wr_q, ctrl_wr_d;
  logic [10:0]              fc_q, fc_d;
  logic [7:0]               res_filt_q, res_filt_d;
  logic [7:0]               mode_vol_q, mode_vol_d;
  logic [7:0]               data_out_q, data_out_d;
  logic                     data_oe_q, data_oe_d;
  logic [7:0]               latch_q, latch_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     cs_prev_q;

  logic       access;
  logic       is_ro;
  logic [7:0] ro_val;
  int         a_int;

  // One access per falling edge of n_cs; cs_prev resets to 1 so a select
  // held low through reset release still starts an access.
  assign access = !n_cs && cs_prev_q;

  always_comb begin
    a_int  = int'(addr);
    is_ro  = (a_int >= B + 4) && (a_int <= B + 7);
    ro_val = 8'h00;
    if (a_int == B + 4)      ro_val = pot_x;
    else if (a_int == B + 5) ro_val = pot_y;
    else if (a_int == B + 6) ro_val = osc_in;
    else if (a_int == B + 7) ro_val = env_in;
  end

  always_comb begin
    freq_d     = freq_q;
    pw_d       = pw_q;
    ctrl_d     = ctrl_q;
    ad_d       = ad_q;
    sr_d       = sr_q;
    ctrl_wr_d  = '0;
    fc_d       = fc_q;
    res_filt_d = res_filt_q;
    mode_vol_d = mode_vol_q;
    data_out_d = data_out_q;
    data_oe_d  = !n_cs && rw;
    latch_d    = latch_q;
    cnt_d      = cnt_q;

    if (access && !rw) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (a_int == 7 * i)     freq_d[16*i +: 8]   = data_in;
        if (a_int == 7 * i + 1) freq_d[16*i+8 +: 8] = data_in;
        if (a_int == 7 * i + 2) pw_d[12*i +: 8]     = data_in;
        if (a_int == 7 * i + 3) pw_d[12*i+8 +: 4]   = data_in[3:0];
        if (a_int == 7 * i + 4) begin
          ctrl_d[8*i +: 8] = data_in;
          ctrl_wr_d[i]     = 1'b1;
        end
        if (a_int == 7 * i + 5) ad_d[8*i +: 8]      = data_in;
        if (a_int == 7 * i + 6) sr_d[8*i +: 8]      = data_in;
      end
      if (a_int == B)     fc_d[2:0]  = data_in[2:0];
      if (a_int == B + 1) fc_d[10:3] = data_in;
      if (a_int == B + 2) res_filt_d = data_in;
      if (a_int == B + 3) mode_vol_d = data_in;
      latch_d = data_in;
      cnt_d   = '0;
    end else if (access && rw) begin
      if (is_ro) begin
        data_out_d = ro_val;
        latch_d    = ro_val;
        cnt_d      = '0;
      end else begin
        data_out_d = latch_q;
      end
    end else if (clk_en && (latch_q != 8'h00)) begin
      // The tick that would bring the count to DECAY_TICKS clears the latch.
      if (cnt_q >= DECAY_LAST) begin
        latch_d = 8'h00;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      freq_q     <= '0;
      pw_q       <= '0;
      ctrl_q     <= '0;
      ad_q       <= '0;
      sr_q       <= '0;
      ctrl_wr_q  <= '0;
      fc_q       <= '0;
      res_filt_q <= '0;
      mode_vol_q <= '0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      latch_q    <= '0;
      cnt_q      <= '0;
      cs_prev_q  <= 1'b1;
    end else begin
      freq_q     <= freq_d;
      pw_q       <= pw_d;
      ctrl_q     <= ctrl_d;
      ad_q       <= ad_d;
      sr_q       <= sr_d;
      ctrl_wr_q  <= ctrl_wr_d;
      fc_q       <= fc_d;
      res_filt_q <= res_filt_d;
      mode_vol_q <= mode_vol_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      latch_q    <= latch_d;
      cnt_q      <= cnt_d;
      cs_prev_q  <= n_cs;
    end
  end

  assign freq     = freq_q;
  assign pw       = pw_q;
  assign ctrl     = ctrl_q;
  assign ad       = ad_q;
  assign sr       = sr_q;
  assign ctrl_wr  = ctrl_wr_q;
  assign fc       = fc_q;
  assign res_filt = res_filt_q;
  assign mode_vol = mode_vol_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;

endmodule

// File: tb/tb_sid_regbank.sv
// tb/tb_sid_regbank.sv - self-checking bench for sid_regbank
module tb_sid_regbank;

  localparam int NV = 3;
  localparam int AW = 5;
  localparam int DT = 20;
  localparam int B  = 7 * NV;
  localparam int RW = 16*NV + 12*NV + 24*NV + 27;

  logic            clk = 1'b0;
  logic            n_reset = 1'b0;
  logic            clk_en = 1'b0;
  logic [AW-1:0]   addr = '0;
  logic [7:0]      data_in = '0;
  logic [7:0]      data_out;
  logic            data_oe;
  logic            n_cs = 1'b1;
  logic            rw = 1'b0;
  logic [16*NV-1:0] freq;
  logic [12*NV-1:0] pw;
  logic [8*NV-1:0]  ctrl, ad, sr;
  logic [NV-1:0]    ctrl_wr;
  logic [10:0]      fc;
  logic [7:0]       res_filt, mode_vol;
  logic [7:0]       pot_x = '0, pot_y = '0, osc_in = '0, env_in = '0;
  logic [RW-1:0]    dut_regs;

  int passed = 0;
  int total  = 0;

  logic [7:0] wmem [0:31];
  logic [7:0] m_latch;
  int         m_ticks;

  sid_regbank #(.NUM_VOICES(NV), .ADDR_W(AW), .DECAY_TICKS(DT)) dut (
    .clk(clk), .n_reset(n_reset), .clk_en(clk_en), .addr(addr), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .n_cs(n_cs), .rw(rw),
    .freq(freq), .pw(pw), .ctrl(ctrl), .ad(ad), .sr(sr), .ctrl_wr(ctrl_wr),
    .fc(fc), .res_filt(res_filt), .mode_vol(mode_vol),
    .pot_x(pot_x), .pot_y(pot_y), .osc_in(osc_in), .env_in(env_in)
  );

  always #5 clk = ~clk;

  assign dut_regs = {freq, pw, ctrl, ad, sr, fc, res_filt, mode_vol};

  // Reference model: last byte written per address, plus latch and decay tick count.
  function automatic logic [RW-1:0] model_regs();
    logic [16*NV-1:0] f;
    logic [12*NV-1:0] p;
    logic [8*NV-1:0]  c, a, s;
    logic [7:0]       hi;
    for (int i = 0; i < NV; i++) begin
      hi = wmem[7*i+3];
      f[16*i +: 16] = {wmem[7*i+1], wmem[7*i]};
      p[12*i +: 12] = {hi[3:0], wmem[7*i+2]};
      c[8*i +: 8]   = wmem[7*i+4];
      a[8*i +: 8]   = wmem[7*i+5];
      s[8*i +: 8]   = wmem[7*i+6];
    end
    hi = wmem[B];
    return {f, p, c, a, s, wmem[B+1], hi[2:0], wmem[B+2], wmem[B+3]};
  endfunction

  function automatic logic [NV-1:0] model_ctrl_wr(input int a);
    logic [NV-1:0] r = '0;
    if (a < B && a % 7 == 4) r[a/7] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) wmem[i] = 8'h00;
    m_latch = 8'h00;
    m_ticks = 0;
  endtask

  task automatic model_write(input int a, input logic [7:0] d);
    if (a < B + 4) wmem[a] = d;
    m_latch = d;
    m_ticks = 0;
  endtask

  task automatic model_read(input int a, output logic [7:0] v);
    if (a >= B + 4 && a <= B + 7) begin
      case (a - B)
        4:       v = pot_x;
        5:       v = pot_y;
        6:       v = osc_in;
        default: v = env_in;
      endcase
      m_latch = v;
      m_ticks = 0;
    end else begin
      v = m_latch;
    end
  endtask

  task automatic bus_write(input int a, input logic [7:0] d);
    @(negedge clk);
    n_cs = 1'b0; rw = 1'b0; addr = AW'(a); data_in = d;
    @(negedge clk);
    n_cs = 1'b1;
    model_write(a, d);
  endtask

  task automatic bus_read(input int a, output logic [7:0] got, output logic oe, output logic [7:0] exp);
    @(negedge clk);
    n_cs = 1'b0; rw = 1'b1; addr = AW'(a);
    @(negedge clk);
    got = data_out;
    oe  = data_oe;
    n_cs = 1'b1; rw = 1'b0;
    model_read(a, exp);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); clk_en = 1'b1;
      @(negedge clk); clk_en = 1'b0;
      if (m_latch != 8'h00) begin
        m_ticks++;
        if (m_ticks == DT) begin
          m_latch = 8'h00;
          m_ticks = 0;
        end
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clk);
    total++; if (dut_regs !== '0) $display("FAIL reset_regs got=%h exp=0", dut_regs); else passed++;
    total++; if ({ctrl_wr, data_out, data_oe} !== '0)
      $display("FAIL reset_bus got=%h/%h/%b exp=0", ctrl_wr, data_out, data_oe); else passed++;
    n_reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ctrl_write();
    bus_write(8'h0B, 8'h41);
    total++; if (ctrl[15:8] !== 8'h41) $display("FAIL ctrl_v1 got=%h exp=41", ctrl[15:8]); else passed++;
    total++; if (ctrl_wr !== 3'b010) $display("FAIL ctrl_wr_pulse got=%b exp=010", ctrl_wr); else passed++;
    total++; if (dut_regs !== model_regs()) $display("FAIL ctrl_others got=%h exp=%h", dut_regs, model_regs()); else passed++;
    @(negedge clk);
    total++; if (ctrl_wr !== 3'b000) $display("FAIL ctrl_wr_end got=%b exp=000", ctrl_wr); else passed++;
  endtask

  task automatic test_hold_single_shot();
    logic [7:0] first;
    first = 8'h3C;
    @(negedge clk);
    n_cs = 1'b0; rw = 1'b0; addr = '0; data_in = first;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      data_in = first + 8'(k * 17);
    end
    @(negedge clk);
    n_cs = 1'b1;
    model_write(0, first);
    total++; if (freq[7:0] !== first) $display("FAIL hold_freq got=%h exp=%h", freq[7:0], first); else passed++;
    total++; if (dut_regs !== model_regs()) $display("FAIL hold_regs got=%h exp=%h", dut_regs, model_regs()); else passed++;
  endtask

  task automatic test_partial_fields();
    logic [7:0] exp_lo;
    exp_lo = wmem[2];
    bus_write(8'h03, 8'hFF);
    total++; if (pw[11:8] !== 4'hF || pw[7:0] !== exp_lo)
      $display("FAIL pw_partial got=%h exp=%h", pw[11:0], {4'hF, exp_lo}); else passed++;
    bus_write(8'h15, 8'hFF);
    total++; if (fc !== 11'h007) $display("FAIL fc_partial got=%h exp=007", fc); else passed++;
    total++; if (dut_regs !== model_regs()) $display("FAIL partial_regs got=%h exp=%h", dut_regs, model_regs()); else passed++;
  endtask

  task automatic test_decay();
    logic [7:0] got, exp;
    logic       oe;
    bus_write(8'h00, 8'hA5);
    bus_read(8'h00, got, oe, exp);
    total++; if (got !== 8'hA5) $display("FAIL latch_read got=%h exp=a5", got); else passed++;
    total++; if (oe !== 1'b1) $display("FAIL oe_read got=%b exp=1", oe); else passed++;
    @(negedge clk);
    total++; if (data_oe !== 1'b0 || data_out !== 8'hA5)
      $display("FAIL oe_drop got=%b/%h exp=0/a5", data_oe, data_out); else passed++;
    tick(DT - 1);
    bus_read(8'h00, got, oe, exp);
    total++; if (got !== 8'hA5) $display("FAIL decay_early got=%h exp=a5", got); else passed++;
    tick(1);
    bus_read(8'h00, got, oe, exp);
    total++; if (got !== 8'h00) $display("FAIL decay_clear got=%h exp=00", got); else passed++;
  endtask

  task automatic test_readonly();
    logic [7:0] got, exp;
    logic       oe;
    env_in = 8'h7C;
    bus_read(B + 7, got, oe, exp);
    total++; if (got !== 8'h7C) $display("FAIL ro_env got=%h exp=7c", got); else passed++;
    bus_read(8'h05, got, oe, exp);
    total++; if (got !== 8'h7C) $display("FAIL ro_latch got=%h exp=7c", got); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] got, exp, d;
    logic       oe;
    int         a, op;
    for (int it = 0; it < 150; it++) begin
      pot_x = 8'($urandom); pot_y = 8'($urandom);
      osc_in = 8'($urandom); env_in = 8'($urandom);
      op = int'($urandom_range(0, 2));
      a  = int'($urandom_range(0, 31));
      if (op == 0) begin
        d = 8'($urandom);
        bus_write(a, d);
        total++; if (dut_regs !== model_regs())
          $display("FAIL rnd_write it=%0d a=%0d got=%h exp=%h", it, a, dut_regs, model_regs()); else passed++;
        total++; if (ctrl_wr !== model_ctrl_wr(a))
          $display("FAIL rnd_ctrl_wr it=%0d got=%b exp=%b", it, ctrl_wr, model_ctrl_wr(a)); else passed++;
      end else if (op == 1) begin
        bus_read(a, got, oe, exp);
        total++; if (got !== exp || oe !== 1'b1)
          $display("FAIL rnd_read it=%0d a=%0d got=%h/%b exp=%h/1", it, a, got, oe, exp); else passed++;
      end else begin
        tick(int'($urandom_range(1, DT + 2)));
        total++; if (dut_regs !== model_regs())
          $display("FAIL rnd_tick it=%0d got=%h exp=%h", it, dut_regs, model_regs()); else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_access();
    bus_write(B + 3, 8'h1F);
    total++; if (mode_vol !== 8'h1F) $display("FAIL mv_write got=%h exp=1f", mode_vol); else passed++;
    @(negedge clk);
    n_cs = 1'b0; rw = 1'b0; addr = 5'd1; data_in = 8'h77;
    n_reset = 1'b0;
    #1;
    model_reset();
    total++; if (dut_regs !== '0 || {ctrl_wr, data_out, data_oe} !== '0)
      $display("FAIL mid_reset got=%h/%h/%h/%b exp=0", dut_regs, ctrl_wr, data_out, data_oe); else passed++;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    model_write(1, 8'h77);
    for (int k = 0; k < 4; k++) begin
      data_in = 8'(8'h30 + k);
      @(negedge clk);
    end
    n_cs = 1'b1;
    total++; if (freq[15:8] !== 8'h77) $display("FAIL post_reset_write got=%h exp=77", freq[15:8]); else passed++;
    total++; if (dut_regs !== model_regs()) $display("FAIL post_reset_regs got=%h exp=%h", dut_regs, model_regs()); else passed++;
  endtask

  initial begin
    test_reset();
    test_ctrl_write();
    test_hold_single_shot();
    test_partial_fields();
    test_decay();
    test_readonly();
    test_random();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
